sipo_deser: RTL and testbench

//  Serial-in/parallel-out deserializer. It sits directly downstream of the 4-bit PISO stage.
//  It consumes the PISO's serial bit and bit-valid pair and rebuilds WIDTH-bit words, LSB first.

---
 rtl/sipo_deser.sv | 119 +++++++++++
 tb/tb_sipo_deser.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/sipo_deser.sv
// rtl/sipo_deser.sv - serial-in/parallel-out deserializer with output FIFO and overflow flag
// Rebuilds WIDTH-bit words LSB first from a serial bit/valid pair and queues them for a valid/ready consumer.
module sipo_deser #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             srl_i,
  input  logic             vld_i,
  input  logic             clr_i,
  output logic [WIDTH-1:0] prl_o,
  output logic             prl_vld_o,
  input  logic             prl_rdy_i,
  output logic             busy_o,
  output logic             ovf_o,
  output logic [CNT_W-1:0] word_cnt_o
);

  localparam int BW = $clog2(WIDTH);
  localparam int AW = $clog2(DEPTH);
  localparam int FW = AW + 1;
  localparam logic [BW-1:0] LAST = BW'(WIDTH - 1);
  localparam logic [FW-1:0] FULL_CNT = FW'(DEPTH);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t             state;
  logic [WIDTH-2:0]   sh;
  logic [BW-1:0]      cnt;
  logic [WIDTH-1:0]   mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [FW-1:0]      fcnt;
  logic [CNT_W-1:0]   word_cnt;
  logic               ovf;

  logic [WIDTH-1:0]   ext;
  logic               complete;
  logic               full;
  logic               pop;
  logic               push;
  logic               drop;

  // ext is the shift register after this cycle's bit; on completion it is the whole word
  assign ext      = {srl_i, sh};
  assign complete = vld_i && (cnt == LAST);
  assign full     = (fcnt == FULL_CNT);
  assign pop      = (fcnt != '0) && prl_rdy_i && !clr_i;
  assign push     = complete && (!full || pop) && !clr_i;
  assign drop     = complete && full && !pop && !clr_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      sh       <= '0;
      cnt      <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fcnt     <= '0;
      word_cnt <= '0;
      ovf      <= 1'b0;
    end else if (clr_i) begin
      state  <= IDLE;
      sh     <= '0;
      cnt    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      fcnt   <= '0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (vld_i) begin
            sh    <= ext[WIDTH-1:1];
            cnt   <= cnt + BW'(1);
            state <= SHIFT;
          end
        end
        SHIFT: begin
          if (vld_i) begin
            sh <= ext[WIDTH-1:1];
            if (complete) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + BW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase

      if (push) begin
        wr_ptr   <= wr_ptr + AW'(1);
        word_cnt <= word_cnt + CNT_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   fcnt <= fcnt + FW'(1);
        2'b01:   fcnt <= fcnt - FW'(1);
        default: fcnt <= fcnt;
      endcase
      if (drop) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= ext;
  end

  assign prl_vld_o  = (fcnt != '0);
  assign prl_o      = prl_vld_o ? mem[rd_ptr] : '0;
  assign busy_o     = (state == SHIFT);
  assign ovf_o      = ovf;
  assign word_cnt_o = word_cnt;

endmodule

// File: tb/tb_sipo_deser.sv
// tb/tb_sipo_deser.sv - table-driven and directed checks of sipo_deser (WIDTH=4, DEPTH=2, CNT_W=8)
module tb_sipo_deser;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       srl = 1'b0;
  logic       vld = 1'b0;
  logic       clr = 1'b0;
  logic       rdy = 1'b0;
  logic [3:0] prl;
  logic       prl_vld;
  logic       busy;
  logic       ovf;
  logic [7:0] word_cnt;

  int errors = 0;
  int checks = 0;

  sipo_deser #(.WIDTH(4), .DEPTH(2), .CNT_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .srl_i      (srl),
    .vld_i      (vld),
    .clr_i      (clr),
    .prl_o      (prl),
    .prl_vld_o  (prl_vld),
    .prl_rdy_i  (rdy),
    .busy_o     (busy),
    .ovf_o      (ovf),
    .word_cnt_o (word_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       s, v, c, r;
    logic [3:0] p;
    logic       pv, b, o;
    logic [7:0] w;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic s, input logic v, input logic c, input logic r,
                     input logic [3:0] p, input logic pv, input logic b, input logic o,
                     input logic [7:0] w);
    vec_t x;
    x.s = s; x.v = v; x.c = c; x.r = r;
    x.p = p; x.pv = pv; x.b = b; x.o = o; x.w = w;
    vq.push_back(x);
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input int idx, input logic [3:0] p, input logic pv,
                         input logic b, input logic o, input logic [7:0] w);
    chk({nm, ".prl"},      idx, 32'(prl),      32'(p));
    chk({nm, ".prl_vld"},  idx, 32'(prl_vld),  32'(pv));
    chk({nm, ".busy"},     idx, 32'(busy),     32'(b));
    chk({nm, ".ovf"},      idx, 32'(ovf),      32'(o));
    chk({nm, ".word_cnt"}, idx, 32'(word_cnt), 32'(w));
  endtask

  task automatic cyc(input logic s, input logic v, input logic c, input logic r);
    srl = s; vld = v; clr = c; rdy = r;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [3:0] wd, input logic r);
    for (int i = 0; i < 4; i++) cyc(wd[i], 1'b1, 1'b0, r);
  endtask

  initial begin
    // T1: 1,0,1,1 -> 4'hD
    add(1,1,0,1, 4'h0,0,1,0,0); add(0,1,0,1, 4'h0,0,1,0,0);
    add(1,1,0,1, 4'h0,0,1,0,0); add(1,1,0,1, 4'hD,1,0,0,1);
    add(0,0,0,1, 4'h0,0,0,0,1);
    // T3: 3, A, 5 with consumer stalled; 5 dropped
    add(1,1,0,0, 4'h0,0,1,0,1); add(1,1,0,0, 4'h0,0,1,0,1);
    add(0,1,0,0, 4'h0,0,1,0,1); add(0,1,0,0, 4'h3,1,0,0,2);
    add(0,1,0,0, 4'h3,1,1,0,2); add(1,1,0,0, 4'h3,1,1,0,2);
    add(0,1,0,0, 4'h3,1,1,0,2); add(1,1,0,0, 4'h3,1,0,0,3);
    add(1,1,0,0, 4'h3,1,1,0,3); add(0,1,0,0, 4'h3,1,1,0,3);
    add(1,1,0,0, 4'h3,1,1,0,3); add(0,1,0,0, 4'h3,1,0,1,3);
    add(0,0,0,1, 4'hA,1,0,1,3); add(0,0,0,1, 4'h0,0,0,1,3);
    add(0,0,1,0, 4'h0,0,0,0,3);
    // T4: FIFO holds 1,2; word 7 completes together with a pop
    add(1,1,0,0, 4'h0,0,1,0,3); add(0,1,0,0, 4'h0,0,1,0,3);
    add(0,1,0,0, 4'h0,0,1,0,3); add(0,1,0,0, 4'h1,1,0,0,4);
    add(0,1,0,0, 4'h1,1,1,0,4); add(1,1,0,0, 4'h1,1,1,0,4);
    add(0,1,0,0, 4'h1,1,1,0,4); add(0,1,0,0, 4'h1,1,0,0,5);
    add(1,1,0,0, 4'h1,1,1,0,5); add(1,1,0,0, 4'h1,1,1,0,5);
    add(1,1,0,0, 4'h1,1,1,0,5); add(0,1,0,1, 4'h2,1,0,0,6);
    add(0,0,0,1, 4'h7,1,0,0,6); add(0,0,0,1, 4'h0,0,0,0,6);
    // T5: word 9 queued, two bits in, clear (with vld/rdy asserted), then 0,1,1,0 -> 6
    add(1,1,0,0, 4'h0,0,1,0,6); add(0,1,0,0, 4'h0,0,1,0,6);
    add(0,1,0,0, 4'h0,0,1,0,6); add(1,1,0,0, 4'h9,1,0,0,7);
    add(1,1,0,0, 4'h9,1,1,0,7); add(1,1,0,0, 4'h9,1,1,0,7);
    add(1,1,1,1, 4'h0,0,0,0,7);
    add(0,1,0,0, 4'h0,0,1,0,7); add(1,1,0,0, 4'h0,0,1,0,7);
    add(1,1,0,0, 4'h0,0,1,0,7); add(0,1,0,0, 4'h6,1,0,0,8);
    add(0,0,0,1, 4'h0,0,0,0,8);

    #1;
    chk_all("reset", 0, 4'h0, 0, 0, 0, 8'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk_all("reset_rel", 0, 4'h0, 0, 0, 0, 8'd0);

    foreach (vq[i]) begin
      cyc(vq[i].s, vq[i].v, vq[i].c, vq[i].r);
      chk_all("table", i, vq[i].p, vq[i].pv, vq[i].b, vq[i].o, vq[i].w);
    end

    // word counter wraps modulo 256 (count is 8 here)
    for (int k = 0; k < 247; k++) send_word(4'h0, 1'b1);
    chk("wrap_pre.word_cnt", 0, 32'(word_cnt), 32'd255);
    send_word(4'h0, 1'b1);
    chk("wrap.word_cnt", 0, 32'(word_cnt), 32'd0);
    chk("wrap.ovf", 0, 32'(ovf), 32'd0);
    cyc(0, 0, 0, 1);
    chk("wrap_drain.prl_vld", 0, 32'(prl_vld), 32'd0);

    // T2: bits of 4'hD separated by 3 idle cycles
    begin
      logic [3:0] wd;
      wd = 4'hD;
      for (int i = 0; i < 4; i++) begin
        cyc(wd[i], 1, 0, 0);
        if (i < 3) begin
          chk_all("gap_bit", i, 4'h0, 0, 1, 0, 8'd0);
          for (int g = 0; g < 3; g++) begin
            cyc(0, 0, 0, 0);
            chk_all("gap_idle", i * 3 + g, 4'h0, 0, 1, 0, 8'd0);
          end
        end
      end
      chk_all("gap_done", 0, 4'hD, 1, 0, 0, 8'd1);
      cyc(0, 0, 0, 1);
      chk_all("gap_pop", 0, 4'h0, 0, 0, 0, 8'd1);
    end

    // T6: async reset mid-word with 4'hC queued
    send_word(4'hC, 1'b0);
    chk_all("rst_fill", 0, 4'hC, 1, 0, 0, 8'd2);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0);
    chk_all("rst_mid", 0, 4'hC, 1, 1, 0, 8'd2);
    rst_n = 1'b0;
    #1;
    chk_all("rst_async", 0, 4'h0, 0, 0, 0, 8'd0);
    cyc(0, 0, 0, 0);
    rst_n = 1'b1;
    send_word(4'h5, 1'b0);
    chk_all("rst_after", 0, 4'h5, 1, 0, 0, 8'd1);
    cyc(0, 0, 0, 1);
    chk_all("rst_after_pop", 0, 4'h0, 0, 0, 0, 8'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
